// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle shared by the command master and its register slave.
// The master modport drives the request channels; the slave modport answers them.
interface axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport m_axil (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s_axil (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready command stream into one
// AXI-Lite write or read and returns one registered response per command, with counters.
module axil_cmd_master #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_we,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic [CNT_WIDTH-1:0]        wr_cnt,
    output logic [CNT_WIDTH-1:0]        rd_cnt,
    output logic [CNT_WIDTH-1:0]        err_cnt,
    axil_if.m_axil                      m_axil
);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

    state_t state, state_next;

    logic cmd_hs, aw_hs, w_hs, aw_fin, w_fin, b_hs, ar_hs, r_hs, rsp_hs;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = m_axil.awvalid && m_axil.awready;
    assign w_hs   = m_axil.wvalid && m_axil.wready;
    assign b_hs   = m_axil.bvalid && m_axil.bready;
    assign ar_hs  = m_axil.arvalid && m_axil.arready;
    assign r_hs   = m_axil.rvalid && m_axil.rready;
    assign rsp_hs = rsp_valid && rsp_ready;

    // A channel is finished once its valid has dropped or is handshaking this cycle,
    // so AW and W may complete in either order or together.
    assign aw_fin = !m_axil.awvalid || m_axil.awready;
    assign w_fin  = !m_axil.wvalid || m_axil.wready;

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_hs) state_next = cmd_we ? WR_AW_W : RD_AR;
            WR_AW_W: if (aw_fin && w_fin) state_next = WR_B;
            WR_B:    if (b_hs) state_next = RSP;
            RD_AR:   if (ar_hs) state_next = RD_R;
            RD_R:    if (r_hs) state_next = RSP;
            RSP:     if (rsp_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // bready/rready are only raised after the address phase, so early responses are ignored.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_we         <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            err_cnt        <= '0;
            m_axil.awvalid <= 1'b0;
            m_axil.wvalid  <= 1'b0;
            m_axil.arvalid <= 1'b0;
            m_axil.bready  <= 1'b0;
            m_axil.rready  <= 1'b0;
            m_axil.awaddr  <= '0;
            m_axil.araddr  <= '0;
            m_axil.wdata   <= '0;
            m_axil.wstrb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        cmd_ready     <= 1'b0;
                        m_axil.awaddr <= cmd_addr;
                        m_axil.araddr <= cmd_addr;
                        m_axil.wdata  <= cmd_wdata;
                        m_axil.wstrb  <= cmd_wstrb;
                        if (cmd_we) begin
                            m_axil.awvalid <= 1'b1;
                            m_axil.wvalid  <= 1'b1;
                        end else begin
                            m_axil.arvalid <= 1'b1;
                        end
                    end
                end
                WR_AW_W: begin
                    if (aw_hs) m_axil.awvalid <= 1'b0;
                    if (w_hs)  m_axil.wvalid  <= 1'b0;
                    if (aw_fin && w_fin) m_axil.bready <= 1'b1;
                end
                WR_B: begin
                    if (b_hs) begin
                        m_axil.bready <= 1'b0;
                        rsp_resp      <= m_axil.bresp;
                        rsp_we        <= 1'b1;
                        rsp_rdata     <= '0;
                        rsp_valid     <= 1'b1;
                        wr_cnt        <= wr_cnt + CNT_WIDTH'(1);
                        if (m_axil.bresp != 2'b00) err_cnt <= err_cnt + CNT_WIDTH'(1);
                    end
                end
                RD_AR: begin
                    if (ar_hs) begin
                        m_axil.arvalid <= 1'b0;
                        m_axil.rready  <= 1'b1;
                    end
                end
                RD_R: begin
                    if (r_hs) begin
                        m_axil.rready <= 1'b0;
                        rsp_rdata     <= m_axil.rdata;
                        rsp_resp      <= m_axil.rresp;
                        rsp_we        <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rd_cnt        <= rd_cnt + CNT_WIDTH'(1);
                        if (m_axil.rresp != 2'b00) err_cnt <= err_cnt + CNT_WIDTH'(1);
                    end
                end
                RSP: begin
                    if (rsp_hs) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
